// File: rtl/conv_window_mac.sv
// Window x kernel multiply-accumulate: serial signed kernel load, 3-stage product/row/total pipeline.
// Optional CONV_WINDOW_MAC_RELU_EN clamps negative sums to zero in the final stage.
module conv_window_mac #(
  parameter int unsigned P_SR_DEPTH  = 3,
  parameter int unsigned NUM_SR_ROWS = 3,
  parameter int unsigned ACC_WIDTH   = 24
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic [8*P_SR_DEPTH*NUM_SR_ROWS-1:0]   window_in,
  input  logic                                  window_valid,
  input  logic                                  weight_start,
  input  logic                                  weight_valid,
  input  logic [7:0]                            weight_in,
  output logic                                  weights_loaded,
  output logic                                  window_accept,
  output logic [ACC_WIDTH-1:0]                  result,
  output logic                                  result_valid
);

  localparam int unsigned K      = P_SR_DEPTH * NUM_SR_ROWS;
  localparam int unsigned IDX_W  = (K > 1) ? $clog2(K) : 1;
  localparam int unsigned PROD_W = 17;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(K - 1);

  logic signed [7:0]           weight_q [K];
  logic [IDX_W-1:0]            load_idx;
  logic [IDX_W-1:0]            write_idx;
  logic signed [PROD_W-1:0]    prod_q [K];
  logic signed [ACC_WIDTH-1:0] row_sum_c [NUM_SR_ROWS];
  logic signed [ACC_WIDTH-1:0] row_q [NUM_SR_ROWS];
  logic signed [ACC_WIDTH-1:0] total_c;
  logic signed [ACC_WIDTH-1:0] final_c;
  logic                        v1;
  logic                        v2;

  // A start pulse coinciding with a write lands that write at index 0.
  assign write_idx     = weight_start ? '0 : load_idx;
  assign window_accept = window_valid & weights_loaded & ~weight_valid & ~weight_start;

  // Kernel storage and serial load index
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < K; i++) weight_q[i] <= '0;
      load_idx       <= '0;
      weights_loaded <= 1'b0;
    end else if (weight_valid) begin
      weight_q[write_idx] <= weight_in;
      if (write_idx == LAST_IDX) begin
        load_idx       <= '0;
        weights_loaded <= 1'b1;
      end else begin
        load_idx       <= write_idx + IDX_W'(1);
        weights_loaded <= 1'b0;
      end
    end else if (weight_start) begin
      load_idx       <= '0;
      weights_loaded <= 1'b0;
    end
  end

  // Stage 1: element-wise products, captured with the kernel present at the accept edge
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < K; i++) prod_q[i] <= '0;
      v1 <= 1'b0;
    end else begin
      v1 <= window_accept;
      if (window_accept) begin
        for (int i = 0; i < K; i++)
          prod_q[i] <= PROD_W'($signed({1'b0, window_in[8*i +: 8]})) * PROD_W'(weight_q[i]);
      end
    end
  end

  always_comb begin
    for (int r = 0; r < NUM_SR_ROWS; r++) begin
      row_sum_c[r] = '0;
      for (int c = 0; c < P_SR_DEPTH; c++)
        row_sum_c[r] = row_sum_c[r] + ACC_WIDTH'(prod_q[r*P_SR_DEPTH + c]);
    end
  end

  always_comb begin
    total_c = '0;
    for (int r = 0; r < NUM_SR_ROWS; r++) total_c = total_c + row_q[r];
`ifdef CONV_WINDOW_MAC_RELU_EN
    final_c = total_c[ACC_WIDTH-1] ? '0 : total_c;
`else
    final_c = total_c;
`endif
  end

  // Stages 2 and 3: row partial sums, then the total; result holds between valid cycles
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NUM_SR_ROWS; r++) row_q[r] <= '0;
      v2           <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
    end else begin
      v2           <= v1;
      result_valid <= v2;
      if (v1) begin
        for (int r = 0; r < NUM_SR_ROWS; r++) row_q[r] <= row_sum_c[r];
      end
      if (v2) result <= final_c;
    end
  end

endmodule
